// File: rtl/btn_conditioner.sv
// Input-side front end for the board game FSM.
//
// Turns the five raw push-buttons into debounced levels plus a one-cycle press pulse, and the
// sixteen raw slide switches into two-flop synchronized copies. Every input bit first goes
// through a 2-flop synchronizer; each button then feeds its own independent debounce FSM.
//
// Ports:
//   clk        in   1   system clock, all logic on posedge
//   reset      in   1   synchronous, active-high reset
//   btn_raw    in   5   raw buttons (asynchronous): [0] center, [1] top, [2] bottom,
//                       [3] left, [4] right
//   sw_raw     in  16   raw slide switches (asynchronous)
//   btn_level  out  5   debounced button level, bit order as btn_raw
//   btn_pulse  out  5   one-cycle pulse per accepted press, bit order as btn_raw
//   sw_sync    out 16   synchronized switches (2-edge latency, no debounce)
module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_WIDTH       = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  btn_raw,
    input  logic [15:0] sw_raw,
    output logic [4:0]  btn_level,
    output logic [4:0]  btn_pulse,
    output logic [15:0] sw_sync
);

    // Terminal count: a new value is accepted on the edge that finds cnt at this value.
    localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StReleased,
        StPressWait,
        StPressed,
        StReleaseWait
    } btn_state_e;

    // ------------------------------------------------------------------------------------------
    // Two-flop synchronizers for every asynchronous input bit
    // ------------------------------------------------------------------------------------------
    logic [4:0]  btn_s1_q, btn_s2_q;
    logic [15:0] sw_s1_q, sw_s2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_s1_q <= '0;
            btn_s2_q <= '0;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
        end else begin
            btn_s1_q <= btn_raw;
            btn_s2_q <= btn_s1_q;
            sw_s1_q  <= sw_raw;
            sw_s2_q  <= sw_s1_q;
        end
    end

    assign sw_sync = sw_s2_q;

    // ------------------------------------------------------------------------------------------
    // Per-button debounce FSMs, fully independent of each other
    // ------------------------------------------------------------------------------------------
    for (genvar k = 0; k < 5; k++) begin : g_btn
        btn_state_e           state_q, state_d;
        logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
        logic                 pulse_q, pulse_d;

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= StReleased;
                cnt_q   <= '0;
                pulse_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pulse_q <= pulse_d;
            end
        end

        // Any reversal of the synchronized input while waiting abandons the transition; the
        // next attempt starts again from cnt = 0.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            pulse_d = 1'b0;
            unique case (state_q)
                StReleased: begin
                    if (btn_s2_q[k]) begin
                        state_d = StPressWait;
                        cnt_d   = '0;
                    end
                end
                StPressWait: begin
                    if (!btn_s2_q[k]) begin
                        state_d = StReleased;
                    end else if (cnt_q == CntLast) begin
                        state_d = StPressed;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StPressed: begin
                    if (!btn_s2_q[k]) begin
                        state_d = StReleaseWait;
                        cnt_d   = '0;
                    end
                end
                StReleaseWait: begin
                    // Returning to PRESSED is a bounce, not a new press: no pulse.
                    if (btn_s2_q[k]) begin
                        state_d = StPressed;
                    end else if (cnt_q == CntLast) begin
                        state_d = StReleased;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StReleased;
                    cnt_d   = '0;
                end
            endcase
        end

        // Level is high in both states where the press has been accepted.
        assign btn_level[k] = (state_q == StPressed) || (state_q == StReleaseWait);
        assign btn_pulse[k] = pulse_q;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner (DEBOUNCE_CYCLES = 4).
//
// The reference model tracks, per button, how many consecutive edges the synchronized input has
// disagreed with the accepted level; DEBOUNCE_CYCLES+1 such edges flip the level, and a flip to
// 1 produces the press pulse. Directed scenarios run first, then randomized stimulus.
module tb_btn_conditioner;

    localparam int unsigned Deb = 4;
    localparam int unsigned CntW = 3;

    logic        clk;
    logic        reset;
    logic [4:0]  btn_raw;
    logic [15:0] sw_raw;
    logic [4:0]  btn_level;
    logic [4:0]  btn_pulse;
    logic [15:0] sw_sync;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(Deb),
        .CNT_WIDTH      (CntW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_raw),
        .sw_raw   (sw_raw),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse),
        .sw_sync  (sw_sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------------------------------------------------------- reference model
    logic [4:0]  m_hist1, m_hist2;   // raw samples taken one and two edges ago
    logic [15:0] m_sw1, m_sw2;
    logic [4:0]  m_level, m_pulse;
    int unsigned m_run [5];

    task automatic model_reset();
        m_hist1 = '0;
        m_hist2 = '0;
        m_sw1   = '0;
        m_sw2   = '0;
        m_level = '0;
        m_pulse = '0;
        for (int k = 0; k < 5; k++) m_run[k] = 0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        if (reset) begin
            model_reset();
        end else begin
            for (int k = 0; k < 5; k++) begin
                m_pulse[k] = 1'b0;
                if (m_hist2[k] != m_level[k]) begin
                    m_run[k]++;
                    if (m_run[k] == Deb + 1) begin
                        m_level[k] = m_hist2[k];
                        m_pulse[k] = m_hist2[k];
                        m_run[k]   = 0;
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
            m_hist2 = m_hist1;
            m_hist1 = btn_raw;
            m_sw2   = m_sw1;
            m_sw1   = sw_raw;
        end
    endtask

    // One clock edge, then compare every output against the model on the falling edge.
    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_eq("btn_level", 32'(btn_level), 32'(m_level));
        check_eq("btn_pulse", 32'(btn_pulse), 32'(m_pulse));
        check_eq("sw_sync", 32'(sw_sync), 32'(m_sw2));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int unsigned pulse_cnt;
    logic        level_dropped;
    int unsigned hold [5];

    initial begin
        model_reset();
        reset   = 1'b1;
        btn_raw = '0;
        sw_raw  = '0;
        @(negedge clk);
        steps(3);
        check_eq("reset_level", 32'(btn_level), 32'h0);
        check_eq("reset_pulse", 32'(btn_pulse), 32'h0);
        check_eq("reset_sw", 32'(sw_sync), 32'h0);
        reset = 1'b0;
        steps(2);

        // Clean press on center: pulse on edge 6 only, no repeat while held.
        btn_raw[0] = 1'b1;
        steps(6);                                   // edges 0..5
        check_eq("clean_no_early_pulse", 32'(btn_pulse), 32'h0);
        check_eq("clean_no_early_level", 32'(btn_level[0]), 32'h0);
        step();                                     // edge 6
        check_eq("clean_pulse", 32'(btn_pulse), 32'h01);
        check_eq("clean_level", 32'(btn_level[0]), 32'h1);
        pulse_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (btn_pulse[0]) pulse_cnt++;
        end
        check_eq("clean_single_pulse", pulse_cnt, 0);
        check_eq("clean_level_held", 32'(btn_level[0]), 32'h1);
        btn_raw[0] = 1'b0;
        steps(10);

        // Bounce on top: 1,0,1,0 then steady 1.
        pulse_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            btn_raw[1] = (i % 2 == 0);
            step();
            if (btn_pulse[1]) pulse_cnt++;
        end
        btn_raw[1] = 1'b1;                          // last 0->1 sample is the next edge
        steps(6);
        if (btn_pulse[1]) pulse_cnt++;
        check_eq("bounce_no_early", pulse_cnt, 0);
        check_eq("bounce_level_low", 32'(btn_level[1]), 32'h0);
        step();
        check_eq("bounce_pulse", 32'(btn_pulse), 32'h02);
        btn_raw[1] = 1'b0;
        steps(10);

        // Release glitch on bottom.
        btn_raw[2] = 1'b1;
        steps(10);
        check_eq("glitch_level_up", 32'(btn_level[2]), 32'h1);
        pulse_cnt     = 0;
        level_dropped = 1'b0;
        btn_raw[2] = 1'b0;
        steps(2);
        btn_raw[2] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (btn_pulse[2]) pulse_cnt++;
            if (!btn_level[2]) level_dropped = 1'b1;
        end
        check_eq("glitch_level_kept", 32'(level_dropped), 32'h0);
        check_eq("glitch_no_pulse", pulse_cnt, 0);
        btn_raw[2] = 1'b0;
        steps(10);

        // Simultaneous left + right, then left alone.
        btn_raw[4:3] = 2'b11;
        steps(6);
        step();
        check_eq("simul_pulse", 32'(btn_pulse), 32'h18);
        step();
        check_eq("simul_pulse_gone", 32'(btn_pulse), 32'h0);
        btn_raw[4:3] = 2'b00;
        steps(8);
        check_eq("simul_released", 32'(btn_level), 32'h0);
        btn_raw[3] = 1'b1;
        steps(6);
        step();
        check_eq("left_again_pulse", 32'(btn_pulse), 32'h08);
        btn_raw[3] = 1'b0;
        steps(10);

        // Reset in the middle of a debounce.
        btn_raw[0] = 1'b1;
        steps(4);                                   // edges 0..3
        reset = 1'b1;
        step();                                     // edge 4
        check_eq("rst_mid_level", 32'(btn_level), 32'h0);
        check_eq("rst_mid_pulse", 32'(btn_pulse), 32'h0);
        reset = 1'b0;
        steps(6);                                   // edges 5..10
        check_eq("rst_mid_no_early", 32'(btn_pulse), 32'h0);
        step();                                     // edge 11
        check_eq("rst_mid_pulse_late", 32'(btn_pulse), 32'h01);
        btn_raw[0] = 1'b0;
        steps(10);

        // Switch synchronizer latency and reset.
        sw_raw = 16'h8001;
        step();
        check_eq("sw_one_edge", 32'(sw_sync), 32'h0);
        step();
        check_eq("sw_two_edges", 32'(sw_sync), 32'h8001);
        reset = 1'b1;
        step();
        check_eq("sw_reset", 32'(sw_sync), 32'h0);
        reset = 1'b0;
        steps(2);

        // Randomized: each button holds a random value for 1..10 cycles, occasional reset.
        for (int k = 0; k < 5; k++) hold[k] = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 5; k++) begin
                if (hold[k] == 0) begin
                    btn_raw[k] = 1'($urandom_range(1, 0));
                    hold[k]    = $urandom_range(10, 1);
                end
                hold[k]--;
            end
            sw_raw = 16'($urandom);
            reset  = ($urandom_range(99, 0) == 0);
            step();
        end
        reset = 1'b0;
        steps(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Input-side front end for the board game FSM. It turns the five raw push-buttons into clean, debounced signals and the 16 raw slide switches into synchronized signals.
- Per button it produces a stable level and a single-cycle press pulse on each accepted press.
- The game FSM consumes these outputs in place of the raw board pins, so one physical press advances exactly one state.

Parameters:
- DEBOUNCE_CYCLES, default 1000000: consecutive cycles a synchronized input must hold a new value before it is accepted. Minimum 1. 1000000 is 10 ms at 100 MHz.
- CNT_WIDTH, default 20: debounce counter width. Must satisfy 2^CNT_WIDTH >= DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- btn_raw  in  5  raw buttons, asynchronous: [0] center, [1] top, [2] bottom, [3] left, [4] right.
- sw_raw  in  16  raw slide switches, asynchronous.
- btn_level  out  5  debounced button level, bit order as btn_raw.
- btn_pulse  out  5  one-cycle pulse per accepted press, bit order as btn_raw.
- sw_sync  out  16  two-flop synchronized switches.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset state:
  - All synchronizer flops 0.
  - All button FSMs in RELEASED.
  - All counters 0.
  - btn_level, btn_pulse and sw_sync all 0.
- Synchronizer:
  - Each btn_raw and sw_raw bit passes through a 2-flop chain (s1, then s2).
  - sw_sync = s2 of the switch chain, so latency is 2 edges. No debounce is applied to switches.
- Button FSM, one independent instance per button. It reads s2 and owns cnt[CNT_WIDTH-1:0].
  - RELEASED (level 0): if s2=1, go to PRESS_WAIT with cnt=0.
  - PRESS_WAIT (level 0):
    - If s2=0, go to RELEASED.
    - Else if cnt==DEBOUNCE_CYCLES-1, go to PRESSED, set level 1 and assert the pulse for one cycle.
    - Else cnt+1.
  - PRESSED (level 1): if s2=0, go to RELEASE_WAIT with cnt=0.
  - RELEASE_WAIT (level 1):
    - If s2=1, go to PRESSED with no pulse.
    - Else if cnt==DEBOUNCE_CYCLES-1, go to RELEASED and set level 0.
    - Else cnt+1.
- Pulse timing:
  - Edge 0 is the first edge that samples raw=1, with raw held high afterwards.
  - btn_pulse[k] and btn_level[k] rise on edge DEBOUNCE_CYCLES+2.
  - btn_pulse[k] is high for exactly one cycle.
  - Release is symmetric: btn_level falls on edge DEBOUNCE_CYCLES+2 after raw falls. No pulse on release.
- Glitch rejection:
  - Any s2 reversal during a *_WAIT state abandons the transition.
  - A later attempt restarts cnt from 0, with no accumulated credit.
- btn_pulse is registered.
  - It never asserts twice for one press, however long the button is held.
  - A new pulse requires a full release (RELEASED reached) followed by a new debounced press.
- Simultaneous buttons:
  - Instances are fully independent. Several btn_pulse bits may assert in the same cycle.
  - Priority among buttons is resolved by the consumer.
- cnt never exceeds DEBOUNCE_CYCLES-1, so there is no wrap.
- Reset mid-operation:
  - Reset overrides all state in the same edge, and any pending pulse or level is cleared.
  - A button held through reset deassertion is treated as a new press: it pulses DEBOUNCE_CYCLES+2 edges after the first post-reset edge.
- Reset has priority over all other transitions in the same cycle.

Test Plan (DEBOUNCE_CYCLES=4):
- Clean press: raise btn_raw[0] before edge 0 and hold it -> btn_pulse=5'b00001 after edge 6 for one cycle only; btn_level[0]=1 from edge 6 on; no further pulse over 100 held cycles.
- Bounce: btn_raw[1] toggles 1,0,1,0 on alternate cycles, then stays 1 -> no pulse during bouncing; one pulse exactly 6 edges after the last 0->1 sample; level stays 0 until then.
- Release glitch: with btn_level[2]=1, drop btn_raw[2] for 2 cycles then restore -> btn_level[2] stays 1 and btn_pulse[2] stays 0.
- Simultaneous press: raise btn_raw[3] and btn_raw[4] on the same edge -> btn_pulse=5'b11000 in one cycle; then release both for 6+ cycles and press btn_raw[3] again -> btn_pulse=5'b01000 once.
- Reset mid-debounce: hold btn_raw[0], assert reset at edge 4 for 1 cycle -> all outputs 0 after edge 4; pulse appears 6 edges after the first post-reset edge.
- Switches: change sw_raw from 16'h0000 to 16'h8001 -> sw_sync=16'h8001 exactly 2 edges later; reset forces sw_sync=0 on the next edge.
